sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Executes the CHIP-8 DXYN draw: fetches N sprite bytes from main memory at I, XORs each with the current framebuffer row and writes the result back to the GPU through its row-write port (x_addr/y_addr/sprite/we_stb).
- Reports collision (VF) to the CPU.
- Sits between the CPU execute stage, main RAM and the GPU framebuffer.

Parameters:
- ADDR_W, 12, main memory address width; I+r wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock (50 MHz domain, same as the GPU write port)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; ignored unless idle
- x_in  in  6  sprite origin column (0..63)
- y_in  in  5  sprite origin row (0..31)
- n_in  in  4  sprite height in rows (0..15)
- i_addr  in  ADDR_W  sprite base address (I register)
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address
- mem_data  in  8  read data, valid the cycle after mem_rd
- fb_rd_y  out  5  framebuffer row select for read-back
- fb_rd_row  in  64  framebuffer row; bit c = column c; valid the cycle after fb_rd_y is driven
- x_addr  out  6  GPU write column origin
- y_addr  out  5  GPU write row
- sprite  out  8  GPU write data; bit k lands at column x_addr+k
- we_stb  out  1  GPU write strobe, one cycle per row write
- busy  out  1  draw in progress
- done  out  1  one-cycle completion pulse
- collision  out  1  VF result, valid from done until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: mem_rd, mem_addr, fb_rd_y, x_addr, y_addr, sprite, we_stb, busy, done, collision. The row counter is cleared. Reset mid-draw aborts immediately; a partially drawn sprite is left as is.
- States: IDLE, FETCH, WAIT, WRITE, DONE.
- IDLE: on start=1, latch x_in/y_in/n_in/i_addr, set r=0 and collision=0.
  - n_in=0 -> DONE.
  - Otherwise -> FETCH.
- FETCH: mem_rd=1, mem_addr=I+r, fb_rd_y=y+r. -> WAIT.
- WAIT: for k=0..7:
  - p[k] = mem_data[7-k] (MSB is leftmost pixel).
  - col = x+k (7-bit, no wrap).
  - If col<64: sprite[k] <= fb_rd_row[col] ^ p[k], and collision <= collision | (fb_rd_row[col] & p[k]).
  - If col>=64: sprite[k] <= 0; the GPU discards these bits and they do not contribute to collision.
  - Register x_addr=x, y_addr=y+r. -> WRITE.
- WRITE: we_stb=1 for exactly one cycle. Then r<=r+1.
  - If r+1==n or y+r+1>31 (bottom clip) -> DONE.
  - Otherwise -> FETCH.
- DONE: done=1 for one cycle, busy=0. -> IDLE. collision holds its value.
- busy=1 in FETCH, WAIT and WRITE only.
- Timing, with start sampled at cycle 0 and no clipping:
  - Row r has FETCH at 3r+1, WAIT at 3r+2 and we_stb at 3r+3.
  - done occurs at cycle 3N+1.
  - n_in=0 gives done at cycle 1 with collision=0.
- start while busy or in DONE is ignored; it is not queued.
- Origin coordinates are inherently modulo screen size by port width. Sprite bodies clip at the right and bottom edges.
- Each row read targets a different row than the preceding write, so there is no read-after-write hazard.

Optional Feature:
- Macro SPRITE_WRAP_EN.
- Defined:
  - Rows wrap: y_addr=(y+r) mod 32, and there is no bottom clip, so exactly N rows are drawn.
  - Columns wrap: when x>56, WRITE is followed by a WRITE2 state that issues a second we_stb with x_addr=0.
  - In WRITE2, for j=0..7: sprite[j] = fb_rd_row[j] ^ p[j+64-x] if j+64-x<=7, else fb_rd_row[j] (unchanged).
  - Wrapped bits contribute to collision. Rows with a wrap take 4 cycles.
- Undefined: clipping behaviour exactly as above. WRITE2 does not exist.

Test Plan:
- Clear screen; x=0, y=0, n=1, mem[I]=0xF0 -> one we_stb at cycle 3 with x_addr=0, y_addr=0, sprite=0x0F; done at cycle 4; collision=0.
- Repeat the same draw over the result (fb row0 bits 0..3 set) -> sprite=0x00, collision=1.
- x=60, y=0, n=1, mem=0xFF, clear screen -> sprite=0x0F, collision=0. With SPRITE_WRAP_EN: a second we_stb with x_addr=0, sprite=0x0F.
- y=30, n=5, I=0x200, mem=0x80 each -> 2 we_stb (y_addr 30, 31), done at cycle 7. With SPRITE_WRAP_EN: 5 we_stb with y_addr 30, 31, 0, 1, 2.
- n=0 -> no mem_rd, no we_stb, done at cycle 1, collision=0. A start pulse while busy -> ignored, with exactly one done.
- Assert rst_n=0 in the WAIT of row 1 of an n=4 draw -> all outputs 0 immediately, no further we_stb, IDLE after release.

Source files
------------

// File: rtl/sprite_blitter.sv
// CHIP-8 DXYN sprite blitter: fetch rows from RAM, XOR them with the framebuffer,
// write the results back to the GPU and report the VF collision flag.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 draw request, accepted only when idle
//   x_in, y_in, n_in      sprite origin column/row and height
//   i_addr                sprite base address (I)
//   mem_rd, mem_addr      RAM read port; mem_data returns a cycle later
//   fb_rd_y, fb_rd_row    framebuffer row read-back; row returns a cycle later
//   x_addr, y_addr        GPU row-write origin
//   sprite, we_stb        GPU row-write data and strobe
//   busy, done            draw in progress, one-cycle completion pulse
//   collision             VF, valid from done until the next accepted start
//
// Build option: SPRITE_WRAP_EN wraps rows and columns instead of clipping.
module sprite_blitter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        x_in,
  input  logic [4:0]        y_in,
  input  logic [3:0]        n_in,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [4:0]        fb_rd_y,
  input  logic [63:0]       fb_rd_row,
  output logic [5:0]        x_addr,
  output logic [4:0]        y_addr,
  output logic [7:0]        sprite,
  output logic              we_stb,
  output logic              busy,
  output logic              done,
  output logic              collision
);

`ifdef SPRITE_WRAP_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, WRITE, WRITE2, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, WRITE, DONE
  } state_t;
`endif

  state_t state, state_d;

  logic [5:0]        x_q;
  logic [4:0]        y_q;
  logic [3:0]        n_q;
  logic [3:0]        r_q;
  logic [ADDR_W-1:0] i_q;

  logic [4:0] row_y;
  logic       last_row;
  logic       row_end;
  logic [7:0] pix;
  logic [7:0] row_bits;
  logic       hit;

  // Row wraps modulo 32 by width; only reachable without clipping in wrap mode.
  assign row_y    = y_q + {1'b0, r_q};
  assign last_row = ({1'b0, r_q} + 5'd1) == {1'b0, n_q};

  // MSB of the sprite byte is the leftmost pixel.
  always_comb begin
    pix = '0;
    for (int k = 0; k < 8; k++) begin
      pix[k] = mem_data[7-k];
    end
  end

  always_comb begin
    row_bits = '0;
    hit      = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [6:0] col;
      col = {1'b0, x_q} + 7'(k);
      if (!col[6]) begin
        row_bits[k] = fb_rd_row[col[5:0]] ^ pix[k];
        hit = hit | (fb_rd_row[col[5:0]] & pix[k]);
      end
    end
  end

`ifdef SPRITE_WRAP_EN
  logic [7:0] wrap_bits;
  logic [7:0] spr2_q;
  logic       wrap_hit;
  logic       wrap_row;

  assign wrap_row = x_q > 6'd56;

  // Pixels that fell off the right edge land at columns 0.. of the same row.
  always_comb begin
    wrap_bits = '0;
    wrap_hit  = 1'b0;
    for (int j = 0; j < 8; j++) begin
      logic [6:0] src;
      src = 7'(j) + 7'd64 - {1'b0, x_q};
      if (src <= 7'd7) begin
        wrap_bits[j] = fb_rd_row[j] ^ pix[src[2:0]];
        wrap_hit = wrap_hit | (fb_rd_row[j] & pix[src[2:0]]);
      end else begin
        wrap_bits[j] = fb_rd_row[j];
      end
    end
  end

  assign row_end = (state == WRITE && !wrap_row) ||
                   (state == WRITE2);
`else
  logic bot_clip;

  assign bot_clip = ({1'b0, y_q} + {2'b0, r_q} + 6'd1) > 6'd31;
  assign row_end  = (state == WRITE);
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = (n_in == 4'd0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT:  state_d = WRITE;
`ifdef SPRITE_WRAP_EN
      WRITE: begin
        if (wrap_row)      state_d = WRITE2;
        else if (last_row) state_d = DONE;
        else               state_d = FETCH;
      end
      WRITE2: state_d = last_row ? DONE : FETCH;
`else
      WRITE: state_d = (last_row || bot_clip) ? DONE : FETCH;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      n_q       <= '0;
      r_q       <= '0;
      i_q       <= '0;
      x_addr    <= '0;
      y_addr    <= '0;
      sprite    <= '0;
      collision <= 1'b0;
`ifdef SPRITE_WRAP_EN
      spr2_q    <= '0;
`endif
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        x_q       <= x_in;
        y_q       <= y_in;
        n_q       <= n_in;
        i_q       <= i_addr;
        r_q       <= '0;
        collision <= 1'b0;
      end
      if (state == WAIT) begin
        sprite <= row_bits;
        x_addr <= x_q;
        y_addr <= row_y;
`ifdef SPRITE_WRAP_EN
        spr2_q    <= wrap_bits;
        collision <= collision | hit | wrap_hit;
`else
        collision <= collision | hit;
`endif
      end
`ifdef SPRITE_WRAP_EN
      if (state == WRITE && wrap_row) begin
        sprite <= spr2_q;
        x_addr <= '0;
      end
`endif
      if (row_end) begin
        r_q <= r_q + 4'd1;
      end
    end
  end

  assign mem_rd   = (state == FETCH);
  assign mem_addr = (state == FETCH) ? i_q + ADDR_W'(r_q) : '0;
  assign fb_rd_y  = (state == FETCH) ? row_y : '0;
  assign done     = (state == DONE);
`ifdef SPRITE_WRAP_EN
  assign we_stb = (state == WRITE) || (state == WRITE2);
  assign busy   = (state == FETCH) || (state == WAIT) ||
                  (state == WRITE) || (state == WRITE2);
`else
  assign we_stb = (state == WRITE);
  assign busy   = (state == FETCH) || (state == WAIT) ||
                  (state == WRITE);
`endif

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a RAM and framebuffer model.
// Cycle k = number of clock edges since (and including) the start edge.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  x_in = '0;
  logic [4:0]  y_in = '0;
  logic [3:0]  n_in = '0;
  logic [11:0] i_addr = '0;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data = '0;
  logic [4:0]  fb_rd_y;
  logic [63:0] fb_rd_row = '0;
  logic [5:0]  x_addr;
  logic [4:0]  y_addr;
  logic [7:0]  sprite;
  logic        we_stb;
  logic        busy;
  logic        done;
  logic        collision;

  sprite_blitter #(.ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_addr(i_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .fb_rd_y(fb_rd_y), .fb_rd_row(fb_rd_row),
    .x_addr(x_addr), .y_addr(y_addr), .sprite(sprite),
    .we_stb(we_stb), .busy(busy), .done(done),
    .collision(collision)
  );

  always #10 clk = ~clk;

  logic [7:0]  mem [4096];
  logic [63:0] fb [32];
  logic        fb_clr = 1'b0;
  logic        fb_wr = 1'b0;
  logic [4:0]  fb_wy = '0;
  logic [63:0] fb_wv = '0;
  int          total_we = 0;

  always @(posedge clk) begin
    mem_data  <= mem_rd ? mem[mem_addr] : 8'h5A;
    fb_rd_row <= fb[fb_rd_y];
    if (fb_clr) begin
      for (int i = 0; i < 32; i++) fb[i] <= '0;
    end else if (fb_wr) begin
      fb[fb_wy] <= fb_wv;
    end
    if (we_stb) begin
      total_we <= total_we + 1;
      for (int k = 0; k < 8; k++) begin
        if (int'(x_addr) + k < 64)
          fb[y_addr][int'(x_addr) + k] <= sprite[k];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         we_cyc [8];
  logic [5:0] we_x [8];
  logic [4:0] we_y [8];
  logic [7:0] we_s [8];
  int         we_n, rd_n, done_n, done_cyc;
  logic       coll, coll_late;

  task automatic clear_fb();
    @(negedge clk); fb_clr = 1'b1;
    @(negedge clk); fb_clr = 1'b0;
  endtask

  task automatic set_fb(input logic [4:0] y, input logic [63:0] v);
    @(negedge clk); fb_wr = 1'b1; fb_wy = y; fb_wv = v;
    @(negedge clk); fb_wr = 1'b0;
  endtask

  task automatic draw(input logic [5:0] x, input logic [4:0] y,
                      input logic [3:0] n, input logic [11:0] ia,
                      input int dup_at);
    we_n = 0; rd_n = 0; done_n = 0; done_cyc = -1;
    coll = 1'b0;
    for (int i = 0; i < 8; i++) begin
      we_cyc[i] = 0; we_x[i] = '0; we_y[i] = '0; we_s[i] = '0;
    end
    @(negedge clk);
    x_in = x; y_in = y; n_in = n; i_addr = ia; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = (k == dup_at);
      if (we_stb) begin
        if (we_n < 8) begin
          we_cyc[we_n] = k; we_x[we_n] = x_addr;
          we_y[we_n] = y_addr; we_s[we_n] = sprite;
        end
        we_n++;
      end
      if (mem_rd) rd_n++;
      if (done) begin
        done_n++;
        if (done_cyc < 0) begin
          done_cyc = k;
          coll = collision;
        end
      end
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
    end
    start = 1'b0;
    coll_late = collision;
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 32; i++) fb[i] = '0;
    mem[12'h300] = 8'hF0;
    mem[12'h308] = 8'h81;
    mem[12'h310] = 8'hFF;
    for (int i = 0; i < 5; i++) mem[12'h200 + i] = 8'h80;
    mem[12'h320] = 8'h01;
    mem[12'h321] = 8'h02;
    for (int i = 0; i < 4; i++) mem[12'h330 + i] = 8'hAA;

    repeat (3) @(negedge clk);
    check("reset_outs", {mem_rd, mem_addr, fb_rd_y, x_addr, y_addr,
                         sprite, we_stb, busy, done, collision}, 64'd0);
    rst_n = 1'b1;
    clear_fb();

    // Single row on a clear screen.
    draw(6'd0, 5'd0, 4'd1, 12'h300, 0);
    check("t1_we_n", 64'(we_n), 64'd1);
    check("t1_we_cyc", 64'(we_cyc[0]), 64'd3);
    check("t1_x", 64'(we_x[0]), 64'd0);
    check("t1_y", 64'(we_y[0]), 64'd0);
    check("t1_spr", 64'(we_s[0]), 64'h0F);
    check("t1_done", 64'(done_cyc), 64'd4);
    check("t1_coll", 64'(coll), 64'd0);
    check("t1_rd_n", 64'(rd_n), 64'd1);
    check("t1_fb0", fb[0], 64'h0F);

    // Same draw again erases it and collides.
    draw(6'd0, 5'd0, 4'd1, 12'h300, 0);
    check("t2_spr", 64'(we_s[0]), 64'h00);
    check("t2_coll", 64'(coll), 64'd1);
    check("t2_coll_hold", 64'(coll_late), 64'd1);
    check("t2_fb0", fb[0], 64'h0);

    // Partial overlap: 0x81 at x=2 over row bits 2,3.
    clear_fb();
    set_fb(5'd5, 64'h0C);
    draw(6'd2, 5'd5, 4'd1, 12'h308, 0);
    check("t3_spr", 64'(we_s[0]), 64'h82);
    check("t3_x", 64'(we_x[0]), 64'd2);
    check("t3_coll", 64'(coll), 64'd1);
    check("t3_fb5", fb[5], 64'h208);

    // Zero height: immediate done, collision cleared.
    draw(6'd0, 5'd0, 4'd0, 12'h300, 0);
    check("t4_rd_n", 64'(rd_n), 64'd0);
    check("t4_we_n", 64'(we_n), 64'd0);
    check("t4_done", 64'(done_cyc), 64'd1);
    check("t4_coll", 64'(coll), 64'd0);

    // Right edge.
    clear_fb();
    draw(6'd60, 5'd0, 4'd1, 12'h310, 0);
    check("t5_x", 64'(we_x[0]), 64'd60);
    check("t5_spr", 64'(we_s[0]), 64'h0F);
    check("t5_coll", 64'(coll), 64'd0);
`ifdef SPRITE_WRAP_EN
    check("t5_we_n", 64'(we_n), 64'd2);
    check("t5_x2", 64'(we_x[1]), 64'd0);
    check("t5_spr2", 64'(we_s[1]), 64'h0F);
    check("t5_done", 64'(done_cyc), 64'd5);
    check("t5_fb0", fb[0], 64'hF000_0000_0000_000F);
`else
    check("t5_we_n", 64'(we_n), 64'd1);
    check("t5_done", 64'(done_cyc), 64'd4);
    check("t5_fb0", fb[0], 64'hF000_0000_0000_0000);
`endif

    // Bottom edge.
    clear_fb();
    draw(6'd0, 5'd30, 4'd5, 12'h200, 0);
    check("t6_y0", 64'(we_y[0]), 64'd30);
    check("t6_y1", 64'(we_y[1]), 64'd31);
    check("t6_spr", 64'(we_s[1]), 64'h01);
    check("t6_coll", 64'(coll), 64'd0);
    check("t6_fb31", fb[31], 64'h1);
`ifdef SPRITE_WRAP_EN
    check("t6_we_n", 64'(we_n), 64'd5);
    check("t6_y2", 64'(we_y[2]), 64'd0);
    check("t6_y4", 64'(we_y[4]), 64'd2);
    check("t6_done", 64'(done_cyc), 64'd16);
`else
    check("t6_we_n", 64'(we_n), 64'd2);
    check("t6_we_cyc1", 64'(we_cyc[1]), 64'd6);
    check("t6_done", 64'(done_cyc), 64'd7);
    check("t6_fb0", fb[0], 64'h0);
`endif

    // Start while busy is dropped.
    clear_fb();
    draw(6'd0, 5'd3, 4'd2, 12'h320, 2);
    check("t7_done_n", 64'(done_n), 64'd1);
    check("t7_done", 64'(done_cyc), 64'd7);
    check("t7_we_n", 64'(we_n), 64'd2);
    check("t7_spr0", 64'(we_s[0]), 64'h80);
    check("t7_spr1", 64'(we_s[1]), 64'h40);
    check("t7_y1", 64'(we_y[1]), 64'd4);

    // Reset during WAIT of row 1 of a 4-row draw.
    clear_fb();
    @(negedge clk);
    x_in = 6'd0; y_in = 5'd10; n_in = 4'd4; i_addr = 12'h330;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("t8_busy_pre", 64'(busy), 64'd1);
    begin
      int we_before;
      we_before = total_we;
      check("t8_we_before", 64'(we_before), 64'(total_we - 0));
      rst_n = 1'b0;
      #1;
      check("t8_rst_outs", {mem_rd, mem_addr, fb_rd_y, x_addr, y_addr,
                            sprite, we_stb, busy, done, collision}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("t8_idle", 64'({busy, done, we_stb}), 64'd0);
      check("t8_no_we", 64'(total_we - we_before), 64'd0);
    end
    check("t8_fb10", fb[10], 64'h55);
    check("t8_fb11", fb[11], 64'h0);
    draw(6'd0, 5'd0, 4'd0, 12'h300, 0);
    check("t8_after_done", 64'(done_cyc), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
